// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives instruction
// memory and buffers {pc, instr} pairs in a small prefetch FIFO.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_halted
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     pc_mem    [FIFO_DEPTH];
    logic [31:0]     instr_mem [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake and push qualification.
    always_comb begin
        full      = (count == CW'(FIFO_DEPTH));
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        push      = (state == FETCH) & ~redirect_valid & (~full | pop);
    end

    // Head of FIFO; zero when empty so reset shows all-zero outputs.
    always_comb begin
        out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
        out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    end

    assign imem_addr    = fetch_pc;
    assign fetch_halted = (state == HALTED);

    // Fetch state: halt is a level, redirect never blocks the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            unique case (state)
                FETCH:   if (halt)  state <= HALTED;
                HALTED:  if (!halt) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Fetch PC: redirect wins over sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // FIFO occupancy and pointers; redirect flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue model checked every cycle plus
// directed literal expectations for each scenario.
module tb_instr_fetch_ctrl;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_halted;

    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic        fetch_halted2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign imem_rdata  = mem(imem_addr);
    assign imem_rdata2 = mem(imem_addr2);

    instr_fetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_halted   (fetch_halted)
    );

    instr_fetch_ctrl #(.RESET_PC(RPC2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .halt           (1'b0),
        .out_valid      (out_valid2),
        .out_ready      (1'b1),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2),
        .fetch_halted   (fetch_halted2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of fetched PCs, next PC and halted flag.
    logic [31:0] q[$];
    logic [31:0] mpc = RPC;
    logic        mhalt = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                mpc   = RPC;
                mhalt = 1'b0;
            end else begin
                logic do_pop;
                logic do_push;
                do_pop  = (q.size() > 0) && out_ready;
                do_push = !mhalt && !redirect_valid &&
                          ((q.size() < DEPTH) || do_pop);
                if (do_pop) void'(q.pop_front());
                if (redirect_valid) begin
                    q.delete();
                    mpc = redirect_pc & 32'hFFFF_FFFC;
                end else if (do_push) begin
                    q.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
                mhalt = halt;
            end
        end
    end

    // Compare DUT against the model every cycle outside reset.
    bit mon = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon && !rst) begin
                chk("m_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
                if (q.size() > 0) begin
                    chk("m_pc", out_pc, q[0]);
                    chk("m_instr", out_instr, mem(q[0]));
                end
                chk("m_addr", imem_addr, mpc);
                chk("m_halted", {31'b0, fetch_halted}, {31'b0, mhalt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] rdy_pat;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_halted", {31'b0, fetch_halted}, 32'd0);
        chk("rst_addr2", imem_addr2, RPC2);

        // 1: streaming from reset, one per cycle from cycle 1
        rst = 1'b0;
        mon = 1'b1;
        @(negedge clk);
        chk("t1_c0_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", {31'b0, out_valid}, 32'd1);
            chk("t1_pc", out_pc, 32'(4 * i));
            chk("t1_instr", out_instr, 32'h1000_0000 + 32'(i));
            if (i < 3) chk("t1_pc_wrap", out_pc2, RPC2 + 32'(4 * i));
        end

        // 2: back-pressure from reset, then drain in order
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("t2_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_pc_hold", out_pc, 32'h0);
        chk("t2_addr_hold", imem_addr, 32'h8);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("t2_drain_pc", out_pc, 32'(4 * i));
        end

        // 3: redirect while full, with a pop in the same cycle
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_flush_valid", {31'b0, out_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h40);
        tick();
        @(negedge clk);
        chk("t3_tgt_valid", {31'b0, out_valid}, 32'd1);
        chk("t3_tgt_pc", out_pc, 32'h40);

        // 4: halt drains the FIFO, resume at held PC
        tick();
        halt = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("t4_halted", {31'b0, fetch_halted}, 32'd1);
        chk("t4_empty", {31'b0, out_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h4C);
        halt = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t4_resume_pc", out_pc, 32'h4C);
        chk("t4_unhalted", {31'b0, fetch_halted}, 32'd0);

        // 5: halt and redirect together
        tick();
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("t5_halted", {31'b0, fetch_halted}, 32'd1);
        chk("t5_addr", imem_addr, 32'h80);
        halt = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t5_first_pc", out_pc, 32'h80);

        // Mixed ready pattern, checked by the model only
        rdy_pat = 4'b1010;
        for (int i = 0; i < 16; i++) begin
            tick();
            out_ready = rdy_pat[i % 4];
        end

        // 6: async reset mid-stream with two entries
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_async_addr", imem_addr, RPC);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_rel_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t6_first_pc", out_pc, RPC);
        @(negedge clk);
        chk("t6_second_pc", out_pc, RPC + 32'd4);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
